// File: rtl/instr_queue_nway.sv
// N-lane in-order instruction queue between Decode and the Scheduler.
// Optional sticky protocol checker: define INSTR_QUEUE_ERR_CHECK_EN.
module instr_queue_nway #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LANES  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES-1:0]             enq_valid_i,
  input  logic [LANES*DATA_W-1:0]      enq_data_i,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [$clog2(LANES+1)-1:0]   deq_cnt_i,
  output logic [LANES*DATA_W-1:0]      deq_data_o,
  output logic [LANES-1:0]             deq_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         enq_ready_o,
  output logic                         stall_o,
  output logic                         err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned DC_W  = $clog2(LANES+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              enq_ready;
  logic [CNT_W-1:0]  n_enq;
  logic [CNT_W-1:0]  n_deq;
  logic [CNT_W-1:0]  deq_ext;
  logic              run;

  // Room for a whole bundle is judged on the current count only.
  assign enq_ready = !stall_i && (count <= CNT_W'(DEPTH - LANES));
  assign deq_ext   = CNT_W'(deq_cnt_i);
  assign n_deq     = (deq_ext > count) ? count : deq_ext;

  // Only the leading run of valid lanes is accepted.
  always_comb begin
    n_enq = '0;
    run   = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (run && enq_valid_i[i]) n_enq = n_enq + CNT_W'(1);
      else                       run   = 1'b0;
    end
    if (!enq_ready) n_enq = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!flush_i && (CNT_W'(i) < n_enq))
        mem[tail + PTR_W'(i)] <= enq_data_i[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    deq_data_o  = '0;
    deq_valid_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (CNT_W'(i) < count) begin
        deq_valid_o[i]                  = 1'b1;
        deq_data_o[i*DATA_W +: DATA_W]  = mem[head + PTR_W'(i)];
      end
    end
  end

  assign count_o     = count;
  assign empty_o     = (count == '0);
  assign full_o      = (count == CNT_W'(DEPTH));
  assign enq_ready_o = enq_ready;
  assign stall_o     = !enq_ready;

`ifdef INSTR_QUEUE_ERR_CHECK_EN
  logic [LANES-1:0] valid_inc;
  logic             err_set;
  logic             err;

  // A prefix mask plus one shares no set bit with itself.
  assign valid_inc = enq_valid_i + LANES'(1);
  assign err_set   = (deq_ext > count)
                  || (enq_ready && (|(enq_valid_i & valid_inc)))
                  || (deq_cnt_i > DC_W'(LANES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_queue_nway.sv
// Directed self-checking bench for instr_queue_nway (DATA_W=64, DEPTH=8, LANES=2).
module tb_instr_queue_nway;

  logic         clk;
  logic         rst_n;
  logic [1:0]   enq_valid;
  logic [127:0] enq_data;
  logic         stall;
  logic         flush;
  logic [1:0]   deq_cnt;
  logic [127:0] deq_data;
  logic [1:0]   deq_valid;
  logic [3:0]   count;
  logic         empty;
  logic         full;
  logic         enq_ready;
  logic         stall_out;
  logic         err;

  int compared   = 0;
  int mismatched = 0;

`ifdef INSTR_QUEUE_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  instr_queue_nway #(.DATA_W(64), .DEPTH(8), .LANES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq_valid_i (enq_valid),
    .enq_data_i  (enq_data),
    .stall_i     (stall),
    .flush_i     (flush),
    .deq_cnt_i   (deq_cnt),
    .deq_data_o  (deq_data),
    .deq_valid_o (deq_valid),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full),
    .enq_ready_o (enq_ready),
    .stall_o     (stall_out),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] d(input int k);
    return 64'hC0DE_0000_0000_0000 + 64'(k);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic [1:0] v, input int a, input int b);
    enq_valid = v;
    enq_data  = {d(b), d(a)};
  endtask

  initial begin
    rst_n = 1'b0; enq_valid = '0; enq_data = '0;
    stall = 1'b0; flush = 1'b0; deq_cnt = '0;
    #3;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_full", 128'(full), 128'd0);
    chk("rst_valid", 128'(deq_valid), 128'd0);
    chk("rst_data", deq_data, 128'd0);
    chk("rst_ready", 128'(enq_ready), 128'd1);
    chk("rst_stall_o", 128'(stall_out), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    stall = 1'b1;
    #1;
    chk("stall_ready", 128'(enq_ready), 128'd0);
    chk("stall_o", 128'(stall_out), 128'd1);
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // fill to full with four bundles
    for (int k = 0; k < 4; k++) begin
      set_enq(2'b11, 2*k, 2*k+1);
      tick;
      chk("fill_count", 128'(count), 128'(2*k+2));
    end
    chk("full_flag", 128'(full), 128'd1);
    chk("full_ready", 128'(enq_ready), 128'd0);
    chk("full_stall_o", 128'(stall_out), 128'd1);
    chk("full_valid", 128'(deq_valid), 128'd3);
    chk("full_head", deq_data, {d(1), d(0)});
    set_enq(2'b11, 100, 101);
    tick;
    chk("fifth_rejected", 128'(count), 128'd8);

    // full: dequeue 2 with enqueue in the same cycle
    deq_cnt = 2'd2;
    tick;
    chk("fulldeq_count", 128'(count), 128'd6);
    chk("fulldeq_head", deq_data, {d(3), d(2)});
    chk("fulldeq_ready", 128'(enq_ready), 128'd1);
    deq_cnt = 2'd0;
    set_enq(2'b11, 8, 9);
    tick;
    chk("refill_count", 128'(count), 128'd8);
    set_enq(2'b00, 0, 0);
    deq_cnt = 2'd2;
    for (int p = 1; p <= 4; p++) begin
      chk("drain_order", deq_data, {d(2*p+1), d(2*p)});
      tick;
    end
    deq_cnt = 2'd0;
    chk("drain_empty", 128'(empty), 128'd1);
    chk("drain_valid", 128'(deq_valid), 128'd0);
    chk("drain_data", deq_data, 128'd0);

    // wrap: fill 6, dequeue 5, enqueue 3 bundles
    for (int j = 0; j < 3; j++) begin
      set_enq(2'b11, 20+2*j, 21+2*j);
      tick;
    end
    set_enq(2'b00, 0, 0);
    deq_cnt = 2'd2; tick;
    deq_cnt = 2'd2; tick;
    deq_cnt = 2'd1; tick;
    deq_cnt = 2'd0;
    chk("wrap_count1", 128'(count), 128'd1);
    chk("wrap_valid1", 128'(deq_valid), 128'd1);
    chk("wrap_one", deq_data, {64'd0, d(25)});
    for (int j = 0; j < 3; j++) begin
      set_enq(2'b11, 26+2*j, 27+2*j);
      tick;
    end
    set_enq(2'b00, 0, 0);
    chk("wrap_count7", 128'(count), 128'd7);
    deq_cnt = 2'd2;
    for (int p = 0; p < 3; p++) begin
      chk("wrap_order", deq_data, {d(26+2*p), d(25+2*p)});
      tick;
    end
    deq_cnt = 2'd0;
    chk("wrap_last", deq_data, {64'd0, d(31)});
    chk("wrap_last_valid", 128'(deq_valid), 128'd1);

    // over-dequeue at count 1
    deq_cnt = 2'd2;
    tick;
    deq_cnt = 2'd0;
    chk("overdeq_count", 128'(count), 128'd0);
    chk("overdeq_empty", 128'(empty), 128'd1);
    chk("overdeq_err", 128'(err), 128'(ERR_EXP));

    // non-prefix mask writes nothing
    set_enq(2'b10, 90, 91);
    tick;
    chk("nonprefix_count", 128'(count), 128'd0);
    chk("nonprefix_err", 128'(err), 128'(ERR_EXP));

    // odd alignment so writes and reads cross index 7 -> 0
    set_enq(2'b01, 40, 99);
    tick;
    chk("partial_count", 128'(count), 128'd1);
    chk("partial_head", deq_data, {64'd0, d(40)});
    set_enq(2'b11, 41, 42);
    tick;
    set_enq(2'b00, 0, 0);
    deq_cnt = 2'd1;
    tick;
    deq_cnt = 2'd0;
    chk("cross_count", 128'(count), 128'd2);
    chk("cross_read", deq_data, {d(42), d(41)});
    set_enq(2'b11, 43, 44); tick;
    set_enq(2'b01, 45, 0);  tick;
    chk("preflush_count", 128'(count), 128'd5);

    // flush wins over same-cycle enqueue/dequeue
    set_enq(2'b11, 70, 71);
    deq_cnt = 2'd1;
    flush = 1'b1;
    tick;
    flush = 1'b0; deq_cnt = 2'd0;
    set_enq(2'b00, 0, 0);
    chk("flush_count", 128'(count), 128'd0);
    chk("flush_empty", 128'(empty), 128'd1);
    chk("flush_valid", 128'(deq_valid), 128'd0);
    chk("flush_err_kept", 128'(err), 128'(ERR_EXP));

    // asynchronous reset mid-fill
    set_enq(2'b11, 50, 51);
    tick;
    set_enq(2'b00, 0, 0);
    chk("midfill_count", 128'(count), 128'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 128'(count), 128'd0);
    chk("arst_empty", 128'(empty), 128'd1);
    chk("arst_valid", 128'(deq_valid), 128'd0);
    chk("arst_data", deq_data, 128'd0);
    chk("arst_err", 128'(err), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_enq(2'b11, 60, 61);
    tick;
    set_enq(2'b00, 0, 0);
    chk("post_rst_count", 128'(count), 128'd2);
    chk("post_rst_data", deq_data, {d(61), d(60)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
